// File: rtl/vid_pkg.sv
// vid_pkg: shared video constants, RGB332 layout and the rectangle record
//   CW            coordinate width
//   RW/GW/BW      RGB332 field widths, *_LSB their bit offsets in a colour byte
//   rect_t        {x0, x1, y0, y1, color}; its bit order matches WR_DATA, so a
//                 cast of WR_DATA yields the rectangle directly
//   H_VIS/V_VIS   visible extents
package vid_pkg;
  localparam int CW = 10;
  localparam int RW = 3;
  localparam int GW = 3;
  localparam int BW = 2;
  localparam int R_LSB = 5;
  localparam int G_LSB = 2;
  localparam int B_LSB = 0;
  localparam int H_VIS = 640;
  localparam int V_VIS = 480;
  localparam int X0_LSB = 38;
  localparam int X1_LSB = 28;
  localparam int Y0_LSB = 18;
  localparam int Y1_LSB = 8;
  localparam int COL_LSB = 0;
  localparam int WR_W = 48;
  typedef struct packed {
    logic [CW-1:0] x0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y0;
    logic [CW-1:0] y1;
    logic [7:0]    color;
  } rect_t;
endpackage

// File: rtl/rect_compositor_if.sv
// rect_compositor_if: rectangle write port and commit handshake
//   WR_VALID/WR_READY  write handshake, WR_IDX target slot, WR_DATA packed rect_t
//   COMMIT             request to publish the shadow table
//   COMMIT_DONE        pulse when the live table has been updated
interface rect_compositor_if;
  import vid_pkg::*;
  logic            WR_VALID;
  logic            WR_READY;
  logic [2:0]      WR_IDX;
  logic [WR_W-1:0] WR_DATA;
  logic            COMMIT;
  logic            COMMIT_DONE;
  modport master (output WR_VALID, WR_IDX, WR_DATA, COMMIT, input WR_READY, COMMIT_DONE);
  modport slave  (input WR_VALID, WR_IDX, WR_DATA, COMMIT, output WR_READY, COMMIT_DONE);
endinterface

// File: rtl/rect_hit.sv
// rect_hit: half-open hit test of one rectangle against the current pixel
//   r_i    rectangle; x1<=x0 or y1<=y0 never hits
//   x_i/y_i pixel coordinates
//   hit_o  pixel inside the rectangle
//   col_o  rectangle colour when hit, zero otherwise
module rect_hit
  import vid_pkg::*;
(
  input  rect_t         r_i,
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  output logic          hit_o,
  output logic [7:0]    col_o
);
  assign hit_o = (x_i >= r_i.x0) && (x_i < r_i.x1) && (y_i >= r_i.y0) && (y_i < r_i.y1);
  assign col_o = hit_o ? r_i.color : 8'h00;
endmodule

// File: rtl/rect_compositor.sv
// rect_compositor: paints NRECT rectangles as RGB332 over BG, 2-cycle pipeline
//   CLK/RST               pixel clock, synchronous active-high reset
//   XPOS/YPOS/DE_IN/HS_IN/VS_IN  raw timing from the sync generator
//   wr                    write port + commit handshake (rect_compositor_if.slave)
//   RED/GREEN/BLUE        pixel colour, HS/VS/DE inputs delayed by 2
// Build option RECT_BLEND_EN: overlapping rects OR their colours instead of
// lowest-index priority.
module rect_compositor
  import vid_pkg::*;
#(
  parameter int         NRECT    = 4,
  parameter logic [7:0] BG       = 8'h00,
  parameter bit         SYNC_POL = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CW-1:0] XPOS,
  input  logic [CW-1:0] YPOS,
  input  logic          DE_IN,
  input  logic          HS_IN,
  input  logic          VS_IN,
  rect_compositor_if.slave wr,
  output logic [RW-1:0] RED,
  output logic [GW-1:0] GREEN,
  output logic [BW-1:0] BLUE,
  output logic          HS,
  output logic          VS,
  output logic          DE
);
  // DONE holds the COMMIT_DONE cycle with the write port still closed, so
  // WR_READY reopens the cycle after the pulse.
  typedef enum logic [1:0] {IDLE, PENDING, DONE} state_t;
  state_t state_q, state_d;
  rect_t shadow_q [NRECT];
  rect_t shadow_d [NRECT];
  rect_t live_q [NRECT];
  rect_t live_d [NRECT];
  logic vs_q, vs_edge, commit, we;
  logic [NRECT-1:0] hit, s1_hit_q;
  logic [7:0] col [NRECT];
  logic [7:0] s1_col_q [NRECT];
  logic s1_de_q, s1_hs_q, s1_vs_q;
  logic [7:0] rgb_d, rgb_q;
  logic de_q, hs_q, vs_oq;
  assign vs_edge = (VS_IN == SYNC_POL) && (vs_q != SYNC_POL);
  assign we = wr.WR_VALID && wr.WR_READY;
  assign wr.WR_READY = state_q == IDLE;
  assign wr.COMMIT_DONE = state_q == DONE;
  always_comb begin
    commit = vs_edge && (state_q == PENDING || (state_q == IDLE && wr.COMMIT));
    state_d = commit ? DONE : state_q == DONE ? IDLE : (state_q == IDLE && wr.COMMIT) ? PENDING : state_q;
  end
  // Live copies the post-write shadow so a write in the commit cycle is included.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NRECT; i++)
      if (we && int'(wr.WR_IDX) == i) shadow_d[i] = rect_t'(wr.WR_DATA);
    live_d = live_q;
    if (commit) live_d = shadow_d;
  end
  for (genvar i = 0; i < NRECT; i++) begin : g_hit
    rect_hit u_hit (.r_i(live_q[i]), .x_i(XPOS), .y_i(YPOS), .hit_o(hit[i]), .col_o(col[i]));
  end
  always_comb begin
    rgb_d = 8'h00;
`ifdef RECT_BLEND_EN
    for (int i = 0; i < NRECT; i++) rgb_d = rgb_d | s1_col_q[i];
    if (s1_hit_q == '0) rgb_d = BG;
`else
    rgb_d = BG;
    for (int i = NRECT - 1; i >= 0; i--) if (s1_hit_q[i]) rgb_d = s1_col_q[i];
`endif
    if (!s1_de_q) rgb_d = 8'h00;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      vs_q <= ~SYNC_POL;
      for (int i = 0; i < NRECT; i++) begin
        shadow_q[i] <= '0;
        live_q[i] <= '0;
        s1_col_q[i] <= '0;
      end
      s1_hit_q <= '0;
      s1_de_q <= 1'b0;
      s1_hs_q <= ~SYNC_POL;
      s1_vs_q <= ~SYNC_POL;
      rgb_q <= '0;
      de_q <= 1'b0;
      hs_q <= ~SYNC_POL;
      vs_oq <= ~SYNC_POL;
    end else begin
      state_q <= state_d;
      vs_q <= VS_IN;
      shadow_q <= shadow_d;
      live_q <= live_d;
      s1_hit_q <= hit;
      s1_col_q <= col;
      s1_de_q <= DE_IN;
      s1_hs_q <= HS_IN;
      s1_vs_q <= VS_IN;
      rgb_q <= rgb_d;
      de_q <= s1_de_q;
      hs_q <= s1_hs_q;
      vs_oq <= s1_vs_q;
    end
  end
  assign RED = rgb_q[R_LSB+:RW];
  assign GREEN = rgb_q[G_LSB+:GW];
  assign BLUE = rgb_q[B_LSB+:BW];
  assign DE = de_q;
  assign HS = hs_q;
  assign VS = vs_oq;
endmodule

// File: doc/rect_compositor.md
# rect_compositor

Pixel-colour stage that sits directly downstream of `videosync`. It consumes the raw pixel coordinates and sync pulses, and paints up to `NRECT` programmable axis-aligned rectangles as RGB332 over a background colour. HS/VS are delayed to stay aligned with the pixel data. Rectangle geometry is loaded through a valid/ready write port into a shadow table, and the shadow table is committed to the live table only at the start of vertical sync, so frames never tear.

## Interface
- `NRECT`, 4: number of rectangles (1..8).
- `BG`, 8'h00: background colour, RGB332 {R[2:0],G[2:0],B[1:0]}.
- `SYNC_POL`, 0: active level of HS_IN/VS_IN; 0 = active-low.
- `CLK` in 1: pixel clock, same clock as `videosync`.
- `RST` in 1: synchronous, active-high reset.
- `XPOS` in 10: pixel column from sync generator.
- `YPOS` in 10: pixel line from sync generator.
- `DE_IN` in 1: visible-area flag (XPOS<640 && YPOS<480).
- `HS_IN` in 1: horizontal sync from sync generator.
- `VS_IN` in 1: vertical sync from sync generator.
- `WR_VALID` in 1: write request.
- `WR_READY` out 1: write port can accept.
- `WR_IDX` in 3: rectangle index; values ≥ NRECT are accepted and discarded.
- `WR_DATA` in 48: {X0[9:0], X1[9:0], Y0[9:0], Y1[9:0], COLOR[7:0]}.
- `COMMIT` in 1: single-cycle request to publish the shadow table.
- `COMMIT_DONE` out 1: one-cycle pulse when the live table is updated.
- `RED` out 3, `GREEN` out 3, `BLUE` out 2: pixel colour.
- `HS` out 1, `VS` out 1, `DE` out 1: HS_IN/VS_IN/DE_IN delayed by 2.

## Operation
- Hit test for rect i: X0 ≤ XPOS < X1 and Y0 ≤ YPOS < Y1, unsigned 10-bit compares. X1 ≤ X0 or Y1 ≤ Y0 means empty (never hits).
- Colour resolve: the lowest-index hit rect supplies COLOR. No hit gives `BG`. DE low forces RGB = 0 regardless.
- Write handshake: a transfer occurs when WR_VALID && WR_READY at a rising CLK edge. It writes shadow[WR_IDX]. The live table is untouched.
- Commit FSM:
  - IDLE: WR_READY = 1. COMMIT moves to PENDING.
  - PENDING: WR_READY = 0. VS edge (VS_IN transitions to the `SYNC_POL` level, detected against a registered copy) copies shadow to live, pulses COMMIT_DONE and returns to IDLE.
- A write accepted in the same cycle as COMMIT is included in that commit.
- COMMIT asserted in the same cycle as a VS edge commits at that edge. COMMIT_DONE pulses the next cycle.
- COMMIT while already PENDING is ignored.
- The live table changes only on a VS edge, which lies outside the visible area, so every visible pixel of a frame uses one table.

## Timing
- Latency is 2 cycles, fixed, for all paths.
  - Stage 1 registers the hit vector, per-rect colours and DE/HS/VS.
  - Stage 2 registers the resolved RGB and DE/HS/VS.
- Throughput is one pixel per cycle with no stalls. Coordinates are sampled every cycle.
- WR_READY falls the cycle after COMMIT is sampled and rises the cycle after COMMIT_DONE.
- Reset values:
  - RGB = 0, DE = 0, COMMIT_DONE = 0, WR_READY = 1.
  - HS and VS = inactive level (~SYNC_POL).
  - FSM = IDLE.
  - Shadow and live tables all-zero (all rects empty, so the screen shows BG).
  - VS edge detector preloaded inactive, so no spurious commit after reset.
- Reset mid-operation: a pending commit is dropped, the pipeline is flushed, and both tables are cleared in the same cycle.

## Configuration
- `RECT_BLEND_EN` defined: colour = bitwise OR of COLOR over all hit rects (additive overlap); `BG` is used only when nothing hits.
- `RECT_BLEND_EN` undefined: lowest-index priority as described above.
- Latency and the interface are identical in both builds.

## Structure
- Package `vid_pkg`:
  - Coordinate width (10) and RGB332 field widths/slices.
  - `rect_t` {x0, x1, y0, y1, color}, WR_DATA packing offsets.
  - Visible extents 640/480.
- Sub-module `rect_hit`: combinational half-open compare of one `rect_t` against XPOS/YPOS, producing a hit bit. It is instantiated NRECT times in a generate loop.
- The FSM, tables, resolve logic and delay pipeline stay in `rect_compositor`.

## Test plan
- Reset, then run a full frame with no writes: RGB = 0 outside DE, = BG inside DE. HS/VS/DE equal inputs delayed by exactly 2 cycles.
- Write rect0 = {0,300,0,300,8'hE0} and COMMIT mid-frame: the current frame stays BG. COMMIT_DONE pulses after the VS edge. The next frame shows RED=7 at (0,0) and at (299,299), and BG at (300,0).
- rect0 = {200,400,150,350,8'h1C}, rect1 = {300,600,180,480,8'h03}: at (350,200) the output is 8'h1C. With `RECT_BLEND_EN` it is 8'h1F.
- COMMIT while PENDING plus WR_VALID: WR_READY = 0 and the write is not accepted until 1 cycle after COMMIT_DONE. A write with WR_IDX=5 (NRECT=4) is accepted and has no visible effect.
- COMMIT coincident with a VS edge: commit applied at that edge and COMMIT_DONE pulses the next cycle. An empty rect {100,100,0,480,8'hFF} never paints.
- RST asserted while PENDING mid-frame: the next cycle has WR_READY = 1, RGB = 0, HS/VS inactive, and no COMMIT_DONE ever appears.
